// File: rtl/axi_lite_reg_file_pkg.sv
// rtl/axi_lite_reg_file_pkg.sv - shared response codes and address decode for the register file
package axi_lite_reg_file_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         IDX_MAX_W   = 16;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] index;
  } addr_dec_t;

  // Any set bit above the index field makes the address invalid, so aliases never hit a register.
  function automatic addr_dec_t addr_to_index(input logic [63:0] addr, input int addr_lsb,
                                              input int idx_bits, input int num_regs);
    addr_dec_t   dec;
    logic [63:0] idx;
    logic [63:0] upper;
    idx       = (addr >> addr_lsb) & ((64'd1 << idx_bits) - 64'd1);
    upper     = (addr >> addr_lsb) >> idx_bits;
    dec.index = idx[IDX_MAX_W-1:0];
    dec.valid = (idx < 64'(num_regs)) && (upper == 64'd0);
    return dec;
  endfunction

endpackage

// File: rtl/axi_lite_reg_file_if.sv
// rtl/axi_lite_reg_file_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi_lite_reg_file_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_reg_file_wr_path.sv
// rtl/axi_lite_reg_file_wr_path.sv - AW/W holding registers, commit strobe and B channel
module axi_lite_reg_file_wr_path
  import axi_lite_reg_file_pkg::*;
#(
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_REGISTERS  = 16,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]     awaddr,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [REGISTER_WIDTH-1:0]     wdata,
  input  logic [REGISTER_WIDTH/8-1:0]   wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  output logic                          commit,
  output logic [IDX_MAX_W-1:0]          commit_index,
  output logic                          commit_valid,
  output logic [REGISTER_WIDTH-1:0]     commit_data,
  output logic [REGISTER_WIDTH/8-1:0]   commit_strb
);
  localparam int ADDR_LSB = $clog2(REGISTER_WIDTH / 8);
  localparam int IDX_BITS = $clog2(NUM_REGISTERS);

  logic                        aw_full_q, aw_full_d;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                        w_full_q, w_full_d;
  logic [REGISTER_WIDTH-1:0]   wdata_q, wdata_d;
  logic [REGISTER_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  addr_dec_t                   dec;

  assign dec    = addr_to_index(64'(awaddr_q), ADDR_LSB, IDX_BITS, NUM_REGISTERS);
  assign commit = aw_full_q & w_full_q & ~bvalid_q;

  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = dec.valid ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end
    if (awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      awaddr_d  = awaddr;
    end
    if (wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign awready      = ~aw_full_q;
  assign wready       = ~w_full_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign commit_index = dec.index;
  assign commit_valid = dec.valid;
  assign commit_data  = wdata_q;
  assign commit_strb  = wstrb_q;

endmodule

// File: rtl/axi_lite_reg_file.sv
// rtl/axi_lite_reg_file.sv - AXI4-Lite register bank with hardware write port and write triggers
module axi_lite_reg_file
  import axi_lite_reg_file_pkg::*;
#(
  parameter int REGISTER_WIDTH = 32,
  parameter int NUM_REGISTERS  = 16,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  axi_lite_reg_file_if.slave                           s_axi,
  output logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] reg_out,
  input  logic [NUM_REGISTERS-1:0]                     hw_wr_en,
  input  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] hw_wr_data,
  output logic [NUM_REGISTERS-1:0]                     axi_ctrl_trigger
);
  localparam int ADDR_LSB = $clog2(REGISTER_WIDTH / 8);
  localparam int IDX_BITS = $clog2(NUM_REGISTERS);

  logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] reg_q, reg_d;
  logic [NUM_REGISTERS-1:0]                     trig_q, trig_d;
  logic                                         rvalid_q, rvalid_d;
  logic [REGISTER_WIDTH-1:0]                    rdata_q, rdata_d;
  logic [1:0]                                   rresp_q, rresp_d;

  logic                        commit;
  logic [IDX_MAX_W-1:0]        commit_index;
  logic                        commit_valid;
  logic [REGISTER_WIDTH-1:0]   commit_data;
  logic [REGISTER_WIDTH/8-1:0] commit_strb;
  addr_dec_t                   ar_dec;
  logic                        ar_hs;
  logic [REGISTER_WIDTH-1:0]   rd_word;

  axi_lite_reg_file_wr_path #(
    .REGISTER_WIDTH(REGISTER_WIDTH),
    .NUM_REGISTERS (NUM_REGISTERS),
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_wr_path (
    .clk         (clk),
    .rst_n       (rst_n),
    .awaddr      (s_axi.awaddr),
    .awvalid     (s_axi.awvalid),
    .awready     (s_axi.awready),
    .wdata       (s_axi.wdata),
    .wstrb       (s_axi.wstrb),
    .wvalid      (s_axi.wvalid),
    .wready      (s_axi.wready),
    .bresp       (s_axi.bresp),
    .bvalid      (s_axi.bvalid),
    .bready      (s_axi.bready),
    .commit      (commit),
    .commit_index(commit_index),
    .commit_valid(commit_valid),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  assign ar_dec = addr_to_index(64'(s_axi.araddr), ADDR_LSB, IDX_BITS, NUM_REGISTERS);
  assign ar_hs  = s_axi.arvalid & ~rvalid_q;

  // Hardware write is applied last so it wins a same-cycle collision; the trigger still fires.
  always_comb begin
    reg_d  = reg_q;
    trig_d = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      if (commit && commit_valid && commit_index == IDX_MAX_W'(i)) begin
        trig_d[i] = 1'b1;
        for (int b = 0; b < REGISTER_WIDTH / 8; b++) begin
          if (commit_strb[b]) reg_d[i][8*b +: 8] = commit_data[8*b +: 8];
        end
      end
      if (hw_wr_en[i]) reg_d[i] = hw_wr_data[i];
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      if (ar_dec.index == IDX_MAX_W'(i)) rd_word = reg_q[i];
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_dec.valid ? rd_word : '0;
      rresp_d  = ar_dec.valid ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_q    <= '0;
      trig_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      reg_q    <= reg_d;
      trig_q   <= trig_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign s_axi.arready    = ~rvalid_q;
  assign s_axi.rvalid     = rvalid_q;
  assign s_axi.rdata      = rdata_q;
  assign s_axi.rresp      = rresp_q;
  assign reg_out          = reg_q;
  assign axi_ctrl_trigger = trig_q;

endmodule

// File: tb/tb_axi_lite_reg_file.sv
// tb/tb_axi_lite_reg_file.sv - directed self-checking bench for axi_lite_reg_file
module tb_axi_lite_reg_file;
  localparam int W = 32;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite_reg_file_if #(.ADDR_W(32), .DATA_W(W)) s_axi ();
  logic [N-1:0][W-1:0] reg_out;
  logic [N-1:0][W-1:0] hw_wr_data;
  logic [N-1:0]        hw_wr_en;
  logic [N-1:0]        trig;
  logic [N-1:0][W-1:0] model;

  axi_lite_reg_file #(.REGISTER_WIDTH(W), .NUM_REGISTERS(N), .AXI_ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axi           (s_axi),
    .reg_out         (reg_out),
    .hw_wr_en        (hw_wr_en),
    .hw_wr_data      (hw_wr_data),
    .axi_ctrl_trigger(trig)
  );

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int base;

  always @(posedge clk) if (|trig) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    s_axi.awaddr = addr; s_axi.awvalid = 1'b1;
    s_axi.wdata = data;  s_axi.wstrb = strb; s_axi.wvalid = 1'b1;
    while (!(s_axi.awready && s_axi.wready) && n < 20) begin tick; n++; end
    check("wr_accept_timeout", n < 20, 1);
    tick;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] exp, input string tag);
    int n = 0;
    s_axi.bready = 1'b1;
    while (!s_axi.bvalid && n < 20) begin tick; n++; end
    check({tag, "_b_timeout"}, n < 20, 1);
    check({tag, "_bresp"}, s_axi.bresp, exp);
    tick;
    s_axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    int n = 0;
    s_axi.araddr = addr; s_axi.arvalid = 1'b1;
    while (!s_axi.arready && n < 20) begin tick; n++; end
    check({tag, "_ar_timeout"}, n < 20, 1);
    tick;
    s_axi.arvalid = 1'b0;
    check({tag, "_rvalid"}, s_axi.rvalid, 1);
    check({tag, "_rdata"}, s_axi.rdata, exp_data);
    check({tag, "_rresp"}, s_axi.rresp, exp_resp);
    s_axi.rready = 1'b1;
    tick;
    s_axi.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0;
    s_axi.wvalid = 1'b0; s_axi.bready = 1'b0; s_axi.araddr = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0; hw_wr_en = '0; hw_wr_data = '0; model = '0;
    repeat (3) tick;
    rst_n = 1'b1;

    check("rst_awready", s_axi.awready, 1);
    check("rst_wready", s_axi.wready, 1);
    check("rst_arready", s_axi.arready, 1);
    check("rst_bvalid", s_axi.bvalid, 0);
    check("rst_rvalid", s_axi.rvalid, 0);
    check("rst_trigger", trig, 0);
    check("rst_regs", reg_out, 0);
    axi_read(32'h08, 32'h0, 2'b00, "rst_rd08");

    // W leads AW by three cycles
    s_axi.wdata = 32'hDEADBEEF; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
    tick;
    s_axi.wvalid = 1'b0;
    tick; tick;
    check("wfirst_wready_held", s_axi.wready, 0);
    s_axi.awaddr = 32'h14; s_axi.awvalid = 1'b1;
    tick;
    s_axi.awvalid = 1'b0;
    check("wfirst_trig_early", trig, 0);
    tick;
    check("wfirst_trig", trig, 16'h0020);
    check("wfirst_reg5", reg_out[5], 32'hDEADBEEF);
    check("wfirst_bvalid", s_axi.bvalid, 1);
    tick;
    check("wfirst_trig_one_cycle", trig, 0);
    wait_b(2'b00, "wfirst");
    model[5] = 32'hDEADBEEF;
    axi_read(32'h14, 32'hDEADBEEF, 2'b00, "wfirst_rd");

    axi_write(32'h00, 32'hAAAAAAAA, 4'hF);
    wait_b(2'b00, "strb_pre");
    axi_write(32'h00, 32'h11223344, 4'h5);
    wait_b(2'b00, "strb");
    model[0] = 32'hAA22AA44;
    axi_read(32'h00, 32'hAA22AA44, 2'b00, "strb_rd");

    base = pulses;
    axi_write(32'h40, 32'h12345678, 4'hF);
    wait_b(2'b10, "bad_wr");
    axi_read(32'h40, 32'h0, 2'b10, "bad_rd");
    check("bad_regs", reg_out, model);
    check("bad_no_trig", pulses - base, 0);

    // hardware write lands on the same edge as the AXI commit
    axi_write(32'h0C, 32'h1, 4'hF);
    hw_wr_en[3] = 1'b1; hw_wr_data[3] = 32'h2;
    tick;
    hw_wr_en = '0;
    check("coll_reg3", reg_out[3], 32'h2);
    check("coll_trig", trig, 16'h0008);
    wait_b(2'b00, "coll");
    model[3] = 32'h2;

    axi_write(32'h18, 32'h66, 4'hF);
    tick;
    check("bp_first_trig", trig, 16'h0040);
    model[6] = 32'h66;
    axi_write(32'h1C, 32'h77, 4'hF);
    base = pulses;
    repeat (5) tick;
    check("bp_no_second_trig", pulses - base, 0);
    check("bp_reg7_pending", reg_out[7], 32'h0);
    check("bp_bvalid_held", s_axi.bvalid, 1);
    check("bp_bresp_held", s_axi.bresp, 2'b00);
    s_axi.bready = 1'b1;
    tick;
    s_axi.bready = 1'b0;
    check("bp_bvalid_drop", s_axi.bvalid, 0);
    tick;
    check("bp_second_trig", trig, 16'h0080);
    check("bp_reg7", reg_out[7], 32'h77);
    wait_b(2'b00, "bp_second");
    model[7] = 32'h77;
    axi_read(32'h1C, 32'h77, 2'b00, "bp_rd");
    check("final_regs", reg_out, model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
